// File: rtl/l2_req_arbiter_pkg.sv
// ============================================================================
// Module   : l2_req_arbiter_pkg
// Purpose  : Shared types and defaults for the L2 request arbiter: requester
//            source encoding, the outstanding-read FIFO entry and the default
//            parameter values.
// Ports    : none (package)
// Config   : L2_ARB_PERF_EN (used by l2_req_arbiter, not referenced here)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2_req_arbiter_pkg;

  localparam int OSTD_DEPTH_DEFAULT = 4;
  localparam int ADDR_W_DEFAULT     = 64;
  localparam int LINE_W_DEFAULT     = 512;

  typedef enum logic {
    SRC_ICACHE = 1'b0,
    SRC_DCACHE = 1'b1
  } src_e;

  // One outstanding read: who asked for it, and whether its response must be
  // swallowed because the icache request was squashed after issue.
  typedef struct packed {
    src_e src;
    logic drop;
  } ostd_entry_t;

endpackage

`default_nettype wire

// File: rtl/l2_req_arbiter_ostd_fifo.sv
// ============================================================================
// Module   : ostd_src_fifo
// Purpose  : Tracks the source of every outstanding memory read in issue
//            order, and marks icache entries as dropped on a squash.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_push/i_push_src - push one entry for a read handshake
//            i_pop           - retire the head (ignored when empty)
//            i_squash        - set drop on every icache entry
//            o_head          - current head entry
//            o_empty/o_full  - occupancy flags
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ostd_src_fifo
  import l2_req_arbiter_pkg::*;
#(
  parameter int DEPTH = OSTD_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_push,
  input  src_e        i_push_src,
  input  logic        i_pop,
  input  logic        i_squash,
  output ostd_entry_t o_head,
  output logic        o_empty,
  output logic        o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  ostd_entry_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '{src: SRC_ICACHE, drop: 1'b0};
      end
    end else begin
      // Marking every slot is safe: stale slots are rewritten on push, and
      // the entry being popped this cycle has already been consumed.
      if (i_squash) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_mem[i].src == SRC_ICACHE) begin
            r_mem[i].drop <= 1'b1;
          end
        end
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{src:  i_push_src,
                             drop: i_squash && (i_push_src == SRC_ICACHE)};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/l2_req_arbiter.sv
// ============================================================================
// Module   : l2_req_arbiter
// Purpose  : Round-robin arbiter sharing one memory request port between the
//            icache miss path and the dcache miss/writeback path, plus an
//            in-order response router that refills the originating cache.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            icache_miss_*            - icache read-miss request
//            dcache_req_*             - dcache read-miss / writeback request
//            mem_req_*                - shared memory request port
//            mem_resp_*               - in-order read responses
//            refill_icache_*/dcache_* - one-cycle refill pulses
//            squash_pipe_i            - drop in-flight icache reads
//            resp_err_o               - sticky: response with nothing pending
//            perf_*_o                 - counters (only with L2_ARB_PERF_EN)
// Config   : L2_ARB_PERF_EN - adds the three 32-bit performance counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_req_arbiter
  import l2_req_arbiter_pkg::*;
#(
  parameter int OSTD_DEPTH = OSTD_DEPTH_DEFAULT,
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int LINE_W     = LINE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss_valid_i,
  output logic              icache_miss_ready_o,
  input  logic [ADDR_W-1:0] icache_miss_addr_i,
  input  logic              dcache_req_valid_i,
  output logic              dcache_req_ready_o,
  input  logic [ADDR_W-1:0] dcache_req_addr_i,
  input  logic              dcache_req_we_i,
  input  logic [LINE_W-1:0] dcache_req_wdata_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_req_we_o,
  output logic [LINE_W-1:0] mem_req_wdata_o,
  input  logic              mem_resp_valid_i,
  output logic              mem_resp_ready_o,
  input  logic [LINE_W-1:0] mem_resp_data_i,
  output logic              refill_icache_valid_o,
  output logic [LINE_W-1:0] refill_icache_data_o,
  output logic              refill_dcache_valid_o,
  output logic [LINE_W-1:0] refill_dcache_data_o,
  input  logic              squash_pipe_i,
  output logic              resp_err_o
`ifdef L2_ARB_PERF_EN
  ,
  output logic [31:0]       perf_icache_grants_o,
  output logic [31:0]       perf_dcache_grants_o,
  output logic [31:0]       perf_full_stall_o
`endif
);

  src_e              r_rr_ptr;
  logic              r_lock;
  src_e              r_lock_src;
  logic              r_refill_ic;
  logic              r_refill_dc;
  logic [LINE_W-1:0] r_refill_data;
  logic              r_resp_err;

  logic        w_fifo_full;
  logic        w_fifo_empty;
  ostd_entry_t w_head;
  logic        w_ic_elig;
  logic        w_dc_elig;
  src_e        w_grant;
  logic        w_ic_sel;
  logic        w_req_valid;
  logic        w_hs;
  logic        w_push;
  logic        w_pop;

  // A requester is eligible only if it can actually be admitted, so the
  // memory side never sees a valid it could accept but we could not track.
  assign w_ic_elig = icache_miss_valid_i & ~squash_pipe_i & ~w_fifo_full;
  assign w_dc_elig = dcache_req_valid_i & (dcache_req_we_i | ~w_fifo_full);

  always_comb begin
    w_grant = r_rr_ptr;
    // Hold a presented-but-stalled request; the lock falls away only if the
    // locked requester itself becomes ineligible (icache squashed).
    if (r_lock && ((r_lock_src == SRC_ICACHE) ? w_ic_elig : w_dc_elig)) begin
      w_grant = r_lock_src;
    end else if (w_ic_elig && !w_dc_elig) begin
      w_grant = SRC_ICACHE;
    end else if (w_dc_elig && !w_ic_elig) begin
      w_grant = SRC_DCACHE;
    end
  end

  assign w_ic_sel    = (w_grant == SRC_ICACHE);
  assign w_req_valid = w_ic_sel ? w_ic_elig : w_dc_elig;

  assign mem_req_valid_o  = w_req_valid & ~rst;
  assign mem_req_addr_o   = w_ic_sel ? icache_miss_addr_i : dcache_req_addr_i;
  assign mem_req_we_o     = ~w_ic_sel & dcache_req_we_i;
  assign mem_req_wdata_o  = dcache_req_wdata_i;
  assign mem_resp_ready_o = ~rst;

  assign w_hs                = mem_req_valid_o & mem_req_ready_i;
  assign icache_miss_ready_o = w_hs & w_ic_sel;
  assign dcache_req_ready_o  = w_hs & ~w_ic_sel;

  assign w_push = w_hs & ~mem_req_we_o;
  assign w_pop  = mem_resp_valid_i & ~w_fifo_empty;

  ostd_src_fifo #(
    .DEPTH (OSTD_DEPTH)
  ) u_ostd_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_src (w_grant),
    .i_pop      (w_pop),
    .i_squash   (squash_pipe_i),
    .o_head     (w_head),
    .o_empty    (w_fifo_empty),
    .o_full     (w_fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr      <= SRC_DCACHE;
      r_lock        <= 1'b0;
      r_lock_src    <= SRC_DCACHE;
      r_refill_ic   <= 1'b0;
      r_refill_dc   <= 1'b0;
      r_refill_data <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      if (w_hs) begin
        r_rr_ptr <= w_ic_sel ? SRC_DCACHE : SRC_ICACHE;
      end
      r_lock        <= w_req_valid & ~mem_req_ready_i;
      r_lock_src    <= w_grant;
      r_refill_ic   <= w_pop & ~w_head.drop & (w_head.src == SRC_ICACHE);
      r_refill_dc   <= w_pop & ~w_head.drop & (w_head.src == SRC_DCACHE);
      if (mem_resp_valid_i) begin
        r_refill_data <= mem_resp_data_i;
      end
      if (mem_resp_valid_i && w_fifo_empty) begin
        r_resp_err <= 1'b1;
      end
    end
  end

  assign refill_icache_valid_o = r_refill_ic & ~rst;
  assign refill_dcache_valid_o = r_refill_dc & ~rst;
  assign refill_icache_data_o  = r_refill_data;
  assign refill_dcache_data_o  = r_refill_data;
  assign resp_err_o            = r_resp_err;

`ifdef L2_ARB_PERF_EN
  logic [31:0] r_perf_ic;
  logic [31:0] r_perf_dc;
  logic [31:0] r_perf_stall;
  logic        w_read_blocked;

  assign w_read_blocked = w_fifo_full &
                          (icache_miss_valid_i | (dcache_req_valid_i & ~dcache_req_we_i));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_ic    <= '0;
      r_perf_dc    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (icache_miss_ready_o) r_perf_ic    <= r_perf_ic + 1'b1;
      if (dcache_req_ready_o)  r_perf_dc    <= r_perf_dc + 1'b1;
      if (w_read_blocked)      r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_icache_grants_o = r_perf_ic;
  assign perf_dcache_grants_o = r_perf_dc;
  assign perf_full_stall_o    = r_perf_stall;
`endif

endmodule

`default_nettype wire
